debug_cmd_responder: RTL and testbench

Target-side end of the host debug link. It pops command bytes from the MIPS-side UART RX FIFO, decodes them, and controls the pipeline (load, run, halt, step). It returns pipeline-latch and register-file snapshots byte-by-byte through the UART TX FIFO, terminating each successful command with 'R' (0x52). It sits inside mips, between the uart instance and the pipeline, instruction memory and register file.

---
 rtl/debug_cmd_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_debug_cmd_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_responder.sv
// debug_cmd_responder
//   Target-side end of the host debug link. Pops command bytes from the UART
//   RX FIFO, decodes them and drives pipeline control (load, run, halt, step).
//   Pipeline-latch and register-file snapshots go back byte by byte, LSB
//   first, through the UART TX FIFO. Each command ends with 'R' (ok) or
//   'E' (error).
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_rx_empty/i_rx_data/o_rd_uart   RX FIFO head and pop strobe
//   i_tx_full/o_tx_data/o_wr_uart    TX FIFO push interface
//   i_if_id..i_mem_wb                pipeline latches to snapshot
//   o_reg_addr/i_reg_data            register-file debug read port
//   o_imem_we/addr/data              instruction-memory write port
//   o_cpu_rst, o_pipe_en, o_step_mode  pipeline control
module debug_cmd_responder #(
   parameter int SIZE            = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_INSTRUCTION = 64,
   parameter int NUM_REGISTERS   = 32,
   parameter int IF_ID_SIZE      = 32,
   parameter int ID_EX_SIZE      = 129,
   parameter int EX_MEM_SIZE     = 77,
   parameter int MEM_WB_SIZE     = 71
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx_empty,
   input  logic [7:0]             i_rx_data,
   output logic                   o_rd_uart,
   input  logic                   i_tx_full,
   output logic [7:0]             o_tx_data,
   output logic                   o_wr_uart,
   input  logic [IF_ID_SIZE-1:0]  i_if_id,
   input  logic [ID_EX_SIZE-1:0]  i_id_ex,
   input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
   input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
   output logic [4:0]             o_reg_addr,
   input  logic [SIZE-1:0]        i_reg_data,
   output logic                   o_imem_we,
   output logic [ADDR_WIDTH-1:0]  o_imem_addr,
   output logic [31:0]            o_imem_data,
   output logic                   o_cpu_rst,
   output logic                   o_pipe_en,
   output logic                   o_step_mode
);

   typedef enum logic [3:0] {
      IDLE, DECODE, LOAD_CNT, LOAD_BYTE, LOAD_WR, SNAP, SEND, SEND_REG, STEP, REPLY
   } state_t;

   localparam int         SHADOW_W = 136;
   localparam logic [7:0] CH_R     = 8'h52;
   localparam logic [7:0] CH_E     = 8'h45;
   localparam logic [4:0] LEN_IF   = 5'((IF_ID_SIZE  + 7) / 8);
   localparam logic [4:0] LEN_IDEX = 5'((ID_EX_SIZE  + 7) / 8);
   localparam logic [4:0] LEN_EXM  = 5'((EX_MEM_SIZE + 7) / 8);
   localparam logic [4:0] LEN_MWB  = 5'((MEM_WB_SIZE + 7) / 8);
   localparam logic [4:0] LAST_REG = 5'(NUM_REGISTERS - 1);

   state_t              state, state_n;
   logic [7:0]          cmd;
   logic [SHADOW_W-1:0] shadow, snap_val;
   logic [4:0]          snap_len, byte_cnt;
   logic [7:0]          n_words, word_k;
   logic [1:0]          byte_idx;
   logic [31:0]         word_buf;
   logic                rd_block;   // forces a gap cycle between pops
   logic                can_pop, n_bad, last_byte, more_regs;

   assign can_pop   = !i_rx_empty && !rd_block && !i_rst;
   assign n_bad     = (i_rx_data == 8'd0) || (int'(i_rx_data) > MAX_INSTRUCTION);
   assign last_byte = (byte_cnt == 5'd1);
   assign more_regs = (cmd == 8'h01) && (o_reg_addr != LAST_REG);

   // Latch selection for the snapshot commands, zero-extended into the shadow.
   always_comb begin
      snap_val = '0;
      snap_len = LEN_IF;
      case (cmd)
         8'h02: begin snap_val[IF_ID_SIZE-1:0]  = i_if_id;  snap_len = LEN_IF;   end
         8'h03: begin snap_val[ID_EX_SIZE-1:0]  = i_id_ex;  snap_len = LEN_IDEX; end
         8'h04: begin snap_val[EX_MEM_SIZE-1:0] = i_ex_mem; snap_len = LEN_EXM;  end
         8'h05: begin snap_val[MEM_WB_SIZE-1:0] = i_mem_wb; snap_len = LEN_MWB;  end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      o_rd_uart = 1'b0;
      o_wr_uart = 1'b0;
      o_imem_we = 1'b0;
      case (state)
         IDLE: if (can_pop) begin
            o_rd_uart = 1'b1;
            state_n   = DECODE;
         end
         DECODE: case (cmd)
            8'h01:                      state_n = SEND_REG;
            8'h02, 8'h03, 8'h04, 8'h05: state_n = SNAP;
            8'h07:                      state_n = LOAD_CNT;
            8'h0A:                      state_n = o_step_mode ? STEP : REPLY;
            default:                    state_n = REPLY;
         endcase
         LOAD_CNT: if (can_pop) begin
            o_rd_uart = 1'b1;
            state_n   = n_bad ? REPLY : LOAD_BYTE;
         end
         LOAD_BYTE: if (can_pop) begin
            o_rd_uart = 1'b1;
            if (byte_idx == 2'd3) state_n = LOAD_WR;
         end
         LOAD_WR: begin
            o_imem_we = 1'b1;
            state_n   = (word_k == n_words - 8'd1) ? REPLY : LOAD_BYTE;
         end
         SNAP:     state_n = SEND;
         SEND_REG: state_n = SEND;
         SEND: if (!i_tx_full) begin
            o_wr_uart = 1'b1;
            if (last_byte) state_n = more_regs ? SEND_REG : REPLY;
         end
         STEP: state_n = REPLY;
         REPLY: if (!i_tx_full) begin
            o_wr_uart = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cmd         <= '0;
         shadow      <= '0;
         byte_cnt    <= '0;
         n_words     <= '0;
         word_k      <= '0;
         byte_idx    <= '0;
         word_buf    <= '0;
         rd_block    <= 1'b0;
         o_tx_data   <= '0;
         o_reg_addr  <= '0;
         o_imem_addr <= '0;
         o_imem_data <= '0;
         o_cpu_rst   <= 1'b0;
         o_pipe_en   <= 1'b0;
         o_step_mode <= 1'b0;
      end else begin
         rd_block  <= o_rd_uart;
         o_cpu_rst <= 1'b0;
         case (state)
            IDLE: if (o_rd_uart) cmd <= i_rx_data;
            DECODE: case (cmd)
               8'h01: o_reg_addr <= '0;
               8'h07: o_pipe_en  <= 1'b0;
               8'h08: begin o_step_mode <= 1'b0; o_tx_data <= CH_R; end
               8'h11: begin
                  o_step_mode <= 1'b1;
                  o_pipe_en   <= 1'b0;
                  o_tx_data   <= CH_R;
               end
               8'h0D: begin
                  o_cpu_rst <= 1'b1;
                  o_pipe_en <= !o_step_mode;
                  o_tx_data <= CH_R;
               end
               8'h0B: begin o_pipe_en <= 1'b0; o_tx_data <= CH_R; end
               // Step: enable goes high here and drops in STEP, one cycle wide.
               8'h0A: if (o_step_mode) o_pipe_en <= 1'b1;
                      else             o_tx_data <= CH_E;
               8'h02, 8'h03, 8'h04, 8'h05: ;
               default: o_tx_data <= CH_E;
            endcase
            LOAD_CNT: if (o_rd_uart) begin
               n_words  <= i_rx_data;
               word_k   <= '0;
               byte_idx <= '0;
               if (n_bad) o_tx_data <= CH_E;
            end
            LOAD_BYTE: if (o_rd_uart) begin
               // Little-endian: bytes enter at the top and drift down.
               word_buf <= {i_rx_data, word_buf[31:8]};
               byte_idx <= byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  o_imem_data <= {i_rx_data, word_buf[31:8]};
                  o_imem_addr <= ADDR_WIDTH'({word_k, 2'b00});
               end
            end
            LOAD_WR: begin
               word_k <= word_k + 8'd1;
               if (word_k == n_words - 8'd1) o_tx_data <= CH_R;
            end
            SNAP: begin
               shadow    <= snap_val;
               o_tx_data <= snap_val[7:0];
               byte_cnt  <= snap_len;
            end
            // Register data is sampled one cycle after o_reg_addr settles.
            SEND_REG: begin
               shadow    <= SHADOW_W'(i_reg_data);
               o_tx_data <= i_reg_data[7:0];
               byte_cnt  <= 5'd4;
            end
            SEND: if (o_wr_uart) begin
               shadow    <= {8'h00, shadow[SHADOW_W-1:8]};
               o_tx_data <= shadow[15:8];
               byte_cnt  <= byte_cnt - 5'd1;
               if (last_byte) begin
                  if (more_regs) o_reg_addr <= o_reg_addr + 5'd1;
                  else           o_tx_data  <= CH_R;
               end
            end
            STEP: begin
               o_pipe_en <= 1'b0;
               o_tx_data <= CH_R;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_cmd_responder.sv
// Directed bench for debug_cmd_responder. Models the RX FIFO as a byte
// queue, records every TX push, imem write, cpu reset pulse and pipe-enable
// cycle, and compares them with hand-computed expectations.
module tb_debug_cmd_responder;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_rx_empty = 1'b1;
   logic [7:0]   i_rx_data = 8'h00;
   logic         o_rd_uart;
   logic         i_tx_full = 1'b0;
   logic [7:0]   o_tx_data;
   logic         o_wr_uart;
   logic [31:0]  i_if_id = '0;
   logic [128:0] i_id_ex = '0;
   logic [76:0]  i_ex_mem = '0;
   logic [70:0]  i_mem_wb = '0;
   logic [4:0]   o_reg_addr;
   logic [31:0]  i_reg_data;
   logic         o_imem_we;
   logic [31:0]  o_imem_addr;
   logic [31:0]  o_imem_data;
   logic         o_cpu_rst;
   logic         o_pipe_en;
   logic         o_step_mode;

   debug_cmd_responder dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rd_uart(o_rd_uart),
      .i_tx_full(i_tx_full), .o_tx_data(o_tx_data), .o_wr_uart(o_wr_uart),
      .i_if_id(i_if_id), .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb),
      .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
      .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
      .o_cpu_rst(o_cpu_rst), .o_pipe_en(o_pipe_en), .o_step_mode(o_step_mode)
   );

   always #5 i_clk = ~i_clk;

   assign i_reg_data = 32'h100 + {27'd0, o_reg_addr};

   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int rst_cnt = 0, pe_cnt = 0, proto_err = 0;
   int checks = 0, errors = 0;
   bit pop_pending = 0, rd_prev = 0;

   // Observe strobes mid-cycle; the DUT acts on them at the next posedge.
   always @(negedge i_clk) begin
      if (o_rd_uart) begin
         if (i_rx_empty || rd_prev) proto_err++;
         pop_pending = 1'b1;
      end
      rd_prev = o_rd_uart;
      if (o_wr_uart) begin
         if (i_tx_full) proto_err++;
         else txq.push_back(o_tx_data);
      end
      if (o_imem_we) begin
         wa.push_back(o_imem_addr);
         wd.push_back(o_imem_data);
      end
      if (o_cpu_rst) rst_cnt++;
      if (o_pipe_en) pe_cnt++;
   end

   // RX FIFO model: retire the popped head just after the edge, present next.
   always @(posedge i_clk) begin
      #1;
      if (pop_pending) begin
         if (rxq.size() > 0) void'(rxq.pop_front());
         pop_pending = 1'b0;
      end
      i_rx_empty = (rxq.size() == 0);
      i_rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b);
      rxq.push_back(b);
   endtask

   task automatic wait_tx(input int n, input string name);
      int cyc = 0;
      while (txq.size() < n && cyc < 3000) begin
         @(posedge i_clk);
         cyc++;
      end
      tick(4);
      checks++;
      if (txq.size() != n) begin
         errors++;
         $display("FAIL %s tx byte count: got %0d, expected %0d", name, txq.size(), n);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(3);
      checks++;
      if ({o_rd_uart, o_wr_uart, o_imem_we, o_cpu_rst} !== 4'b0000) begin
         errors++;
         $display("FAIL reset strobes: got %b, expected 0000",
                  {o_rd_uart, o_wr_uart, o_imem_we, o_cpu_rst});
      end
      checks++;
      if (o_tx_data !== 8'h00 || o_reg_addr !== 5'd0) begin
         errors++;
         $display("FAIL reset tx/reg: got %h/%h, expected 00/00", o_tx_data, o_reg_addr);
      end
      checks++;
      if (o_imem_addr !== 32'd0 || o_imem_data !== 32'd0) begin
         errors++;
         $display("FAIL reset imem: got %h/%h, expected 0/0", o_imem_addr, o_imem_data);
      end
      checks++;
      if (o_pipe_en !== 1'b0 || o_step_mode !== 1'b0) begin
         errors++;
         $display("FAIL reset mode: got pe=%b step=%b, expected 0/0", o_pipe_en, o_step_mode);
      end
      i_rst = 1'b0;
      tick(1);
   endtask

   task automatic test_load_reset();
      int cyc = 0;
      wa.delete(); wd.delete(); txq.delete();
      send(8'h07); send(8'h02);
      send(8'h01); send(8'h00); send(8'h01); send(8'h3C); send(8'h11); send(8'h22);
      while ((rxq.size() != 0 || pop_pending) && cyc < 500) begin
         @(posedge i_clk);
         cyc++;
      end
      tick(4);
      checks++;
      if (wa.size() != 1) begin
         errors++;
         $display("FAIL pre-reset writes: got %0d, expected 1", wa.size());
      end
      i_rst = 1'b1;
      tick(2);
      checks++;
      if (o_imem_data !== 32'd0) begin
         errors++;
         $display("FAIL mid-load reset data: got %h, expected 0", o_imem_data);
      end
      i_rst = 1'b0;
      wa.delete(); wd.delete(); txq.delete();
      tick(1);
      send(8'h07); send(8'h01); send(8'h01); send(8'h00); send(8'h01); send(8'h3C);
      wait_tx(1, "reload");
      checks++;
      if (wa.size() != 1) begin
         errors++;
         $display("FAIL reload write count: got %0d, expected 1", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 32'd0 || wd[0] !== 32'h3C010001) begin
            errors++;
            $display("FAIL reload write: got %h@%h, expected 3c010001@0", wd[0], wa[0]);
         end
      end
      checks++;
      if (txq.size() < 1 || txq[0] !== 8'h52) begin
         errors++;
         $display("FAIL reload reply: got %h, expected 52", txq.size() ? txq[0] : 8'hxx);
      end
   endtask

   task automatic test_load();
      logic [7:0] v[10] = '{8'h07, 8'h02, 8'h01, 8'h00, 8'h01, 8'h3C,
                            8'h03, 8'h00, 8'h03, 8'h3C};
      wa.delete(); wd.delete(); txq.delete();
      pe_cnt = 0;
      foreach (v[i]) send(v[i]);
      wait_tx(1, "load2");
      checks++;
      if (wa.size() != 2) begin
         errors++;
         $display("FAIL load2 write count: got %0d, expected 2", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 32'd0 || wd[0] !== 32'h3C010001) begin
            errors++;
            $display("FAIL load2 word0: got %h@%h, expected 3c010001@0", wd[0], wa[0]);
         end
         checks++;
         if (wa[1] !== 32'd4 || wd[1] !== 32'h3C030003) begin
            errors++;
            $display("FAIL load2 word1: got %h@%h, expected 3c030003@4", wd[1], wa[1]);
         end
      end
      checks++;
      if (pe_cnt != 0) begin
         errors++;
         $display("FAIL load2 pipe_en cycles: got %0d, expected 0", pe_cnt);
      end
      checks++;
      if (txq.size() < 1 || txq[0] !== 8'h52) begin
         errors++;
         $display("FAIL load2 reply: got %h, expected 52", txq.size() ? txq[0] : 8'hxx);
      end
   endtask

   task automatic test_load_bad();
      wa.delete(); txq.delete();
      send(8'h07); send(8'h00); send(8'h07); send(8'h41);
      wait_tx(2, "load_bad");
      checks++;
      if (wa.size() != 0) begin
         errors++;
         $display("FAIL load_bad writes: got %0d, expected 0", wa.size());
      end
      checks++;
      if (txq.size() < 2 || txq[0] !== 8'h45 || txq[1] !== 8'h45) begin
         errors++;
         $display("FAIL load_bad replies: got %0d bytes, expected 45 45", txq.size());
      end
   endtask

   task automatic test_snap();
      int cyc = 0;
      logic [7:0] exp;
      txq.delete();
      i_id_ex = '0;
      i_id_ex[128] = 1'b1;
      i_id_ex[0] = 1'b1;
      send(8'h03);
      while (txq.size() < 5 && cyc < 500) begin
         @(posedge i_clk);
         cyc++;
      end
      #1;
      i_tx_full = 1'b1;
      repeat (20) @(posedge i_clk);
      #1;
      i_id_ex = '1;   // must not leak into the frozen snapshot
      i_tx_full = 1'b0;
      wait_tx(18, "snap_idex");
      for (int i = 0; i < 18; i++) begin
         exp = (i == 0 || i == 16) ? 8'h01 : (i == 17) ? 8'h52 : 8'h00;
         checks++;
         if (i >= txq.size() || txq[i] !== exp) begin
            errors++;
            $display("FAIL snap_idex byte %0d: got %h, expected %h", i,
                     i < txq.size() ? txq[i] : 8'hxx, exp);
         end
      end
      txq.delete();
      i_if_id = 32'h12345678;
      send(8'h02);
      wait_tx(5, "snap_ifid");
      checks++;
      if (txq.size() != 5 || {txq[0], txq[1], txq[2], txq[3], txq[4]} !== 40'h7856341252) begin
         errors++;
         $display("FAIL snap_ifid bytes: got %0d bytes, expected 78 56 34 12 52", txq.size());
      end
      txq.delete();
      i_mem_wb = '1;
      send(8'h05);
      wait_tx(10, "snap_memwb");
      for (int i = 0; i < 10; i++) begin
         exp = (i < 8) ? 8'hFF : (i == 8) ? 8'h7F : 8'h52;
         checks++;
         if (i >= txq.size() || txq[i] !== exp) begin
            errors++;
            $display("FAIL snap_memwb byte %0d: got %h, expected %h", i,
                     i < txq.size() ? txq[i] : 8'hxx, exp);
         end
      end
   endtask

   task automatic test_step();
      txq.delete();
      pe_cnt = 0;
      rst_cnt = 0;
      send(8'h11);
      wait_tx(1, "stepmode");
      checks++;
      if (o_step_mode !== 1'b1) begin
         errors++;
         $display("FAIL stepmode flag: got %b, expected 1", o_step_mode);
      end
      send(8'h0D); send(8'h0A);
      wait_tx(3, "step_run");
      checks++;
      if (txq.size() != 3 || {txq[0], txq[1], txq[2]} !== 24'h525252) begin
         errors++;
         $display("FAIL step_run replies: got %0d bytes, expected 52 52 52", txq.size());
      end
      checks++;
      if (rst_cnt != 1) begin
         errors++;
         $display("FAIL step_run cpu_rst pulses: got %0d, expected 1", rst_cnt);
      end
      checks++;
      if (pe_cnt != 1 || o_pipe_en !== 1'b0) begin
         errors++;
         $display("FAIL step_run pipe_en: got %0d cycles, now %b, expected 1, 0", pe_cnt, o_pipe_en);
      end
      txq.delete();
      send(8'h08); send(8'h0A);
      wait_tx(2, "cont_step");
      checks++;
      if (txq.size() != 2 || {txq[0], txq[1]} !== 16'h5245) begin
         errors++;
         $display("FAIL cont_step replies: got %0d bytes, expected 52 45", txq.size());
      end
      checks++;
      if (pe_cnt != 1 || o_step_mode !== 1'b0) begin
         errors++;
         $display("FAIL cont_step state: got pe=%0d step=%b, expected 1, 0", pe_cnt, o_step_mode);
      end
      txq.delete();
      send(8'h0D);
      wait_tx(1, "run");
      checks++;
      if (o_pipe_en !== 1'b1 || rst_cnt != 2) begin
         errors++;
         $display("FAIL run: got pe=%b rst=%0d, expected 1, 2", o_pipe_en, rst_cnt);
      end
      txq.delete();
      send(8'h0B);
      wait_tx(1, "halt");
      checks++;
      if (o_pipe_en !== 1'b0 || txq.size() < 1 || txq[0] !== 8'h52) begin
         errors++;
         $display("FAIL halt: got pe=%b, expected 0 with reply 52", o_pipe_en);
      end
   endtask

   task automatic test_regdump();
      logic [7:0] exp;
      txq.delete();
      send(8'h01); send(8'h99);
      wait_tx(130, "regdump");
      for (int i = 0; i < 130; i++) begin
         if (i == 128)      exp = 8'h52;
         else if (i == 129) exp = 8'h45;
         else if (i % 4 == 0) exp = 8'(i / 4);
         else if (i % 4 == 1) exp = 8'h01;
         else               exp = 8'h00;
         checks++;
         if (i >= txq.size() || txq[i] !== exp) begin
            errors++;
            $display("FAIL regdump byte %0d: got %h, expected %h", i,
                     i < txq.size() ? txq[i] : 8'hxx, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_reset();
      test_load();
      test_load_bad();
      test_snap();
      test_step();
      test_regdump();
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL handshake violations: got %0d, expected 0", proto_err);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
